// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Drives an external CHUNK_W-bit combinational adder one slice per cycle to
//   build a WIDTH-bit add (LSB slice first, carry chained between slices).
//   Request and result each use a valid/ready handshake.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           request handshake
//   in_a, in_b, in_cin          request operands (WIDTH, WIDTH, 1)
//   add_a, add_b, add_cin       slice operands to the adder (zero when not running)
//   add_sum, add_cout           adder result, same cycle
//   out_valid/out_ready         result handshake
//   out_sum, out_cout           full sum and carry out of the top slice
//   busy                        high while a request is in flight (RUN or DONE)
module multiword_add_seq #(
    parameter  int CHUNK_W = 4,
    parameter  int NCHUNK  = 4,
    localparam int WIDTH   = CHUNK_W * NCHUNK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    output logic [CHUNK_W-1:0] add_a,
    output logic [CHUNK_W-1:0] add_b,
    output logic               add_cin,
    input  logic [CHUNK_W-1:0] add_sum,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_cout,
    output logic               busy
);

    // Keep the slice index at least one bit wide so NCHUNK=1 still elaborates.
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               cin_q,   cin_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cin_d   = in_cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_q[32'(idx_q) * CHUNK_W +: CHUNK_W];
                add_b   = b_q[32'(idx_q) * CHUNK_W +: CHUNK_W];
                // Slice 0 takes the request carry; later slices take the chained carry.
                add_cin = (idx_q == '0) ? cin_q : carry_q;
                sum_d[32'(idx_q) * CHUNK_W +: CHUNK_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Gate with rst_n so nothing is accepted during the reset cycle.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
